// File: rtl/neopixel_strand_controller.sv
// Five-pixel NeoPixel strand controller: byte-wise image loading, serial transmit, 2500-cycle latch gap.
// Optional macro NEOPIXEL_AUTO_CLEAR_EN clears the image when the latch gap ends.
module neopixel_strand_controller (
    input  logic         clock,
    input  logic         reset,
    input  logic [7:0]   color_level,
    input  logic [1:0]   color_index,
    input  logic [2:0]   pixel_index,
    input  logic         load_color,
    input  logic         send_it,
    output logic         neo_data,
    output logic         ready_to_load,
    output logic         ready_to_send,
    output logic [119:0] display_packet
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT50
    } state_t;

    state_t       r_state;
    logic [119:0] r_shift;
    logic [6:0]   r_sendCount;
    logic [5:0]   r_bitCycle;
    logic [11:0]  r_wait50Count;

    logic [6:0]   w_pixelBase;
    logic [6:0]   w_colorOffset;
    logic [6:0]   w_byteLsb;
    logic         w_loadValid;
    logic         w_lastCycleOfBit;
    logic         w_nextBit;
    logic [5:0]   w_nextCycle;
    logic         w_nextHigh;

    // Each pixel is stored as {G,R,B}, pixel 0 in the top 24 bits.
    always_comb begin
        w_pixelBase = 7'd0;
        case (pixel_index)
            3'd0:    w_pixelBase = 7'd96;
            3'd1:    w_pixelBase = 7'd72;
            3'd2:    w_pixelBase = 7'd48;
            3'd3:    w_pixelBase = 7'd24;
            default: w_pixelBase = 7'd0;
        endcase
        w_colorOffset = 7'd0;
        case (color_index)
            2'd0:    w_colorOffset = 7'd8;
            2'd2:    w_colorOffset = 7'd16;
            default: w_colorOffset = 7'd0;
        endcase
    end

    assign w_byteLsb = w_pixelBase + w_colorOffset;

    // A send request in IDLE takes priority over a simultaneous load.
    assign w_loadValid = load_color && ready_to_load && (color_index != 2'd3) &&
                         (pixel_index <= 3'd4) && !((r_state == IDLE) && send_it);

    assign w_lastCycleOfBit = (r_bitCycle == 6'd61);
    assign w_nextBit        = w_lastCycleOfBit ? r_shift[118] : r_shift[119];
    assign w_nextCycle      = w_lastCycleOfBit ? 6'd0 : (r_bitCycle + 6'd1);
    assign w_nextHigh       = (w_nextCycle < (w_nextBit ? 6'd35 : 6'd18));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= IDLE;
            r_shift        <= '0;
            r_sendCount    <= '0;
            r_bitCycle     <= '0;
            r_wait50Count  <= '0;
            display_packet <= '0;
            neo_data       <= 1'b0;
            ready_to_load  <= 1'b1;
            ready_to_send  <= 1'b1;
        end else begin
            if (w_loadValid) begin
                display_packet[w_byteLsb +: 8] <= color_level;
            end
            case (r_state)
                IDLE: begin
                    if (send_it) begin
                        r_state       <= SEND;
                        r_shift       <= display_packet;
                        r_sendCount   <= '0;
                        r_bitCycle    <= '0;
                        neo_data      <= 1'b1;
                        ready_to_load <= 1'b0;
                        ready_to_send <= 1'b0;
                    end
                end
                SEND: begin
                    if (w_lastCycleOfBit && (r_sendCount == 7'd119)) begin
                        r_state       <= WAIT50;
                        r_wait50Count <= '0;
                        neo_data      <= 1'b0;
                        ready_to_load <= 1'b1;
                    end else begin
                        // neo_data is registered, so it is computed for the upcoming cycle.
                        if (w_lastCycleOfBit) begin
                            r_sendCount <= r_sendCount + 7'd1;
                            r_shift     <= {r_shift[118:0], 1'b0};
                        end
                        r_bitCycle <= w_nextCycle;
                        neo_data   <= w_nextHigh;
                    end
                end
                WAIT50: begin
                    if (r_wait50Count == 12'd2499) begin
                        r_state       <= IDLE;
                        ready_to_send <= 1'b1;
`ifdef NEOPIXEL_AUTO_CLEAR_EN
                        display_packet <= '0;
`else
                        r_wait50Count <= '0;
`endif
                    end else begin
                        r_wait50Count <= r_wait50Count + 12'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neopixel_strand_controller.sv
// Self-checking bench for neopixel_strand_controller: a frame-timing model checked every cycle
// plus directed literal expectations for loads, pulse widths, latch gap and reset.
module tb_neopixel_strand_controller;

    logic         clock;
    logic         reset;
    logic [7:0]   color_level;
    logic [1:0]   color_index;
    logic [2:0]   pixel_index;
    logic         load_color;
    logic         send_it;
    logic         neo_data;
    logic         ready_to_load;
    logic         ready_to_send;
    logic [119:0] display_packet;

    int errors = 0;
    int checks = 0;

    neopixel_strand_controller dut (
        .clock          (clock),
        .reset          (reset),
        .color_level    (color_level),
        .color_index    (color_index),
        .pixel_index    (pixel_index),
        .load_color     (load_color),
        .send_it        (send_it),
        .neo_data       (neo_data),
        .ready_to_load  (ready_to_load),
        .ready_to_send  (ready_to_send),
        .display_packet (display_packet)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    // Behavioural model: a frame is sent for 120*62 cycles after the send edge, then 2500 quiet cycles.
    logic [119:0] mPacket;
    logic [119:0] mFrame;
    bit           mActive;
    int           edgeCount;
    int           sendEdge;
    bit           compareEn;

    initial begin
        mPacket   = '0;
        mFrame    = '0;
        mActive   = 0;
        edgeCount = 0;
        sendEdge  = -100000;
        compareEn = 0;
    end

    always @(posedge clock) begin
        int  kPre;
        int  lsb;
        bit  inIdle;
        bit  inSend;
        edgeCount = edgeCount + 1;
        if (reset) begin
            mPacket = '0;
            mActive = 0;
        end else begin
            kPre   = edgeCount - 1 - sendEdge;
            inIdle = !mActive || (kPre >= 9940);
            inSend = mActive && (kPre < 7440);
            if (inIdle && send_it) begin
                mActive  = 1;
                sendEdge = edgeCount;
                mFrame   = mPacket;
            end else if (load_color && !inSend && color_index != 2'd3 && pixel_index <= 3'd4) begin
                lsb = 96 - 24 * int'(pixel_index) +
                      ((color_index == 2'd2) ? 16 : (color_index == 2'd0) ? 8 : 0);
                mPacket[lsb +: 8] = color_level;
            end
`ifdef NEOPIXEL_AUTO_CLEAR_EN
            if (mActive && kPre == 9939) mPacket = '0;
`endif
        end
    end

    function automatic logic expectedNeo(input int k);
        int bitPos;
        int phase;
        logic b;
        if (!mActive || k < 0 || k >= 7440) return 1'b0;
        bitPos = 119 - k / 62;
        phase  = k % 62;
        b      = mFrame[bitPos];
        return (phase < (b ? 35 : 18)) ? 1'b1 : 1'b0;
    endfunction

    always @(negedge clock) begin
        int   kNow;
        logic eNeo;
        logic eRtl;
        logic eRts;
        if (compareEn) begin
            kNow = edgeCount - sendEdge;
            eNeo = expectedNeo(kNow);
            eRtl = !(mActive && kNow < 7440);
            eRts = !mActive || (kNow >= 9940);
            checks = checks + 1;
            if (neo_data !== eNeo || ready_to_load !== eRtl || ready_to_send !== eRts ||
                display_packet !== mPacket) begin
                errors = errors + 1;
                $display("[TB] FAIL cycle_compare edge %0d: neo got %b want %b, rtl got %b want %b, rts got %b want %b, pkt got %h want %h",
                         edgeCount, neo_data, eNeo, ready_to_load, eRtl, ready_to_send, eRts,
                         display_packet, mPacket);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [119:0] actual, input logic [119:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic [2:0] pix, input logic [1:0] col,
                                 input logic [7:0] lvl, input logic snd);
        load_color  = ld;
        pixel_index = pix;
        color_index = col;
        color_level = lvl;
        send_it     = snd;
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        load_color  = 1'b0;
        pixel_index = 3'd0;
        color_index = 2'd0;
        color_level = 8'd0;
        send_it     = 1'b0;
    endtask

    task automatic waitUntilCycle(input int target);
        int budget;
        budget = 20000;
        @(negedge clock);
        while ((edgeCount - sendEdge) != target && budget > 0) begin
            @(negedge clock);
            budget = budget - 1;
        end
        if (budget == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL wait_cycle_%0d: got timeout expected cycle reached", target);
        end
    endtask

    task automatic measurePulse(output int hi, output int lo);
        hi = 0;
        lo = 0;
        while (neo_data === 1'b1 && hi < 100) begin
            hi = hi + 1;
            @(negedge clock);
        end
        while (neo_data === 1'b0 && lo < 100) begin
            lo = lo + 1;
            @(negedge clock);
        end
    endtask

    localparam logic [119:0] LoadedPkt = 120'h005077_000000_B30000_000000_00FF00;
`ifdef NEOPIXEL_AUTO_CLEAR_EN
    localparam logic [119:0] AfterFramePkt = 120'h0;
`else
    localparam logic [119:0] AfterFramePkt = 120'h005077_000000_B30000_110000_00FF00;
`endif

    initial begin
        int hi;
        int lo;
        idleInputs();
        reset = 1'b1;
        @(posedge clock);
        #1;
        compareEn = 1;
        @(posedge clock);
        #1;
        reset = 1'b0;

        checkOutput("reset_packet", display_packet, 120'h0);
        checkOutput("reset_neo", {119'd0, neo_data}, 120'd0);
        checkOutput("reset_rtl", {119'd0, ready_to_load}, 120'd1);
        checkOutput("reset_rts", {119'd0, ready_to_send}, 120'd1);

        applyStimulus(1'b1, 3'd4, 2'd0, 8'hFF, 1'b0);
        applyStimulus(1'b1, 3'd0, 2'd1, 8'h77, 1'b0);
        applyStimulus(1'b1, 3'd2, 2'd2, 8'hB3, 1'b0);
        applyStimulus(1'b1, 3'd1, 2'd3, 8'hD4, 1'b0);
        applyStimulus(1'b1, 3'd0, 2'd0, 8'h50, 1'b0);
        idleInputs();
        checkOutput("loads_packet", display_packet, LoadedPkt);
        checkOutput("loads_model", mPacket, LoadedPkt);

        applyStimulus(1'b1, 3'd6, 2'd0, 8'hAA, 1'b0);
        idleInputs();
        checkOutput("bad_pixel_packet", display_packet, LoadedPkt);

        applyStimulus(1'b0, 3'd0, 2'd0, 8'h00, 1'b1);
        idleInputs();
        waitUntilCycle(0);
        checkOutput("send_rtl_low", {119'd0, ready_to_load}, 120'd0);
        measurePulse(hi, lo);
        checkOutput("bit119_high", 120'(hi), 120'd18);
        checkOutput("bit119_low", 120'(lo), 120'd44);

        waitUntilCycle(558);
        measurePulse(hi, lo);
        checkOutput("bit110_high", 120'(hi), 120'd35);
        checkOutput("bit110_low", 120'(lo), 120'd27);

        applyStimulus(1'b0, 3'd0, 2'd0, 8'h00, 1'b1);
        idleInputs();

        waitUntilCycle(7440);
        checkOutput("wait_neo", {119'd0, neo_data}, 120'd0);
        checkOutput("wait_rtl", {119'd0, ready_to_load}, 120'd1);
        checkOutput("wait_rts", {119'd0, ready_to_send}, 120'd0);

        waitUntilCycle(8000);
        applyStimulus(1'b1, 3'd3, 2'd2, 8'h11, 1'b0);
        idleInputs();

        waitUntilCycle(9939);
        checkOutput("rts_before_idle", {119'd0, ready_to_send}, 120'd0);
        waitUntilCycle(9940);
        checkOutput("rts_idle", {119'd0, ready_to_send}, 120'd1);
        checkOutput("after_frame_packet", display_packet, AfterFramePkt);

        applyStimulus(1'b1, 3'd1, 2'd0, 8'hEE, 1'b1);
        idleInputs();
        checkOutput("send_beats_load", display_packet, AfterFramePkt);

        waitUntilCycle(3100);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("abort_packet", display_packet, 120'h0);
        checkOutput("abort_neo", {119'd0, neo_data}, 120'd0);
        checkOutput("abort_rts", {119'd0, ready_to_send}, 120'd1);
        checkOutput("abort_rtl", {119'd0, ready_to_load}, 120'd1);

        repeat (5) @(posedge clock);
        #1;
        compareEn = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
